// File: rtl/io_pkg.sv
// Shared constants and state types for the UART-backed processor I/O bridge.
package io_pkg;

    localparam int UART_FRAME_BITS = 10;

    localparam int ERR_OVERRUN = 0;
    localparam int ERR_FRAMING = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DONE    = 2'd1,
        RELEASE = 2'd2
    } io_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Show-ahead synchronous FIFO; a pop in the same cycle frees room for a push
// into a full FIFO.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/io_uart_bridge.sv
// Serves the processor's level read/write handshake from an 8N1 UART with
// RX and TX byte FIFOs; serialisers are inline.
module io_uart_bridge
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       io_read_req,
    input  logic       io_write_req,
    input  logic [7:0] io_wdata,
    output logic       io_ready,
    output logic       io_done,
    output logic [7:0] io_rdata,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [1:0] uart_err
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    io_state_e     r_state;
    logic [7:0]    r_rdata;
    logic          w_rx_pop;
    logic          w_tx_push;

    logic [7:0]    w_rx_dout;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [7:0]    w_tx_dout;
    logic          w_tx_full;
    logic          w_tx_empty;

    logic          r_tx_busy;
    logic [8:0]    r_tx_shift;
    logic [3:0]    r_tx_bitcnt;
    logic [CW-1:0] r_tx_clkcnt;
    logic          r_txd;
    logic          w_tx_tick;
    logic          w_tx_last;
    logic          w_tx_pop;

    logic [1:0]    r_rx_sync;
    logic          r_rx_prev;
    logic          w_rx_bit;
    rx_state_e     r_rx_state;
    logic [CW-1:0] r_rx_clkcnt;
    logic [2:0]    r_rx_bitcnt;
    logic [7:0]    r_rx_shift;
    logic          r_rx_push;
    logic [7:0]    r_rx_byte;
    logic [1:0]    r_err;

    assign io_ready = (r_state == IDLE);
    assign io_done  = (r_state == DONE);
    assign io_rdata = r_rdata;
    assign uart_txd = r_txd;
    assign uart_err = r_err;

    // A raised read request masks any simultaneous write until the next IDLE.
    always_comb begin
        w_rx_pop  = 1'b0;
        w_tx_push = 1'b0;
        if (r_state == IDLE) begin
            if (io_read_req)       w_rx_pop  = !w_rx_empty;
            else if (io_write_req) w_tx_push = !w_tx_full;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rx_pop) begin
                        r_rdata <= w_rx_dout;
                        r_state <= DONE;
                    end else if (w_tx_push) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= RELEASE;
                RELEASE: if (!io_read_req && !io_write_req) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_push  (r_rx_push),
        .i_din   (r_rx_byte),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_push  (w_tx_push),
        .i_din   (io_wdata),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    // Next byte is loaded on the last stop-bit cycle so frames run back to back.
    assign w_tx_tick = r_tx_busy && (r_tx_clkcnt == CNT_LAST);
    assign w_tx_last = w_tx_tick && (r_tx_bitcnt == 4'(UART_FRAME_BITS - 1));
    assign w_tx_pop  = !w_tx_empty && (!r_tx_busy || w_tx_last);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_tx_busy   <= 1'b0;
            r_tx_shift  <= '1;
            r_tx_bitcnt <= '0;
            r_tx_clkcnt <= '0;
            r_txd       <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_busy   <= 1'b1;
            r_tx_shift  <= {1'b1, w_tx_dout};
            r_tx_bitcnt <= '0;
            r_tx_clkcnt <= '0;
            r_txd       <= 1'b0;
        end else if (w_tx_last) begin
            r_tx_busy   <= 1'b0;
            r_tx_clkcnt <= '0;
            r_txd       <= 1'b1;
        end else if (w_tx_tick) begin
            r_txd       <= r_tx_shift[0];
            r_tx_shift  <= {1'b1, r_tx_shift[8:1]};
            r_tx_bitcnt <= r_tx_bitcnt + 1'b1;
            r_tx_clkcnt <= '0;
        end else if (r_tx_busy) begin
            r_tx_clkcnt <= r_tx_clkcnt + 1'b1;
        end
    end

    assign w_rx_bit = r_rx_sync[1];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rx_sync   <= '1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_clkcnt <= '0;
            r_rx_bitcnt <= '0;
            r_rx_shift  <= '0;
            r_rx_push   <= 1'b0;
            r_rx_byte   <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], uart_rxd};
            r_rx_prev <= w_rx_bit;
            r_rx_push <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !w_rx_bit) begin
                        r_rx_state  <= RX_START;
                        r_rx_clkcnt <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_clkcnt == CNT_HALF) begin
                        r_rx_clkcnt <= '0;
                        r_rx_bitcnt <= '0;
                        r_rx_state  <= w_rx_bit ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_clkcnt <= r_rx_clkcnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_clkcnt == CNT_LAST) begin
                        r_rx_clkcnt <= '0;
                        r_rx_shift  <= {w_rx_bit, r_rx_shift[7:1]};
                        if (r_rx_bitcnt == 3'd7) r_rx_state <= RX_STOP;
                        else                     r_rx_bitcnt <= r_rx_bitcnt + 1'b1;
                    end else begin
                        r_rx_clkcnt <= r_rx_clkcnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_clkcnt == CNT_LAST) begin
                        r_rx_clkcnt <= '0;
                        r_rx_state  <= RX_IDLE;
                        if (w_rx_bit) begin
                            r_rx_push <= 1'b1;
                            r_rx_byte <= r_rx_shift;
                        end
                    end else begin
                        r_rx_clkcnt <= r_rx_clkcnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_err <= '0;
        end else begin
            if (r_rx_state == RX_STOP && r_rx_clkcnt == CNT_LAST && !w_rx_bit)
                r_err[ERR_FRAMING] <= 1'b1;
            if (r_rx_push && w_rx_full && !w_rx_pop)
                r_err[ERR_OVERRUN] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_uart_bridge.sv
// Randomised and directed bench for io_uart_bridge against a queue-based
// model of the RX/TX byte streams and sticky error flags.
module tb_io_uart_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       io_read_req = 1'b0;
    logic       io_write_req = 1'b0;
    logic [7:0] io_wdata = 8'h00;
    logic       io_ready;
    logic       io_done;
    logic [7:0] io_rdata;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;
    logic [1:0] uart_err;

    always #5 CLK = ~CLK;

    io_uart_bridge #(
        .CLKS_PER_BIT (CPB),
        .RX_DEPTH     (DEPTH),
        .TX_DEPTH     (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .io_read_req  (io_read_req),
        .io_write_req (io_write_req),
        .io_wdata     (io_wdata),
        .io_ready     (io_ready),
        .io_done      (io_done),
        .io_rdata     (io_rdata),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd),
        .uart_err     (uart_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [1:0] m_err = 2'b00;
    logic [7:0] m_rdata = 8'h00;
    bit         rx_busy = 1'b0;
    bit         in_rst = 1'b1;
    bit         mon_busy = 1'b0;
    int         rst_gen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checks of protocol invariants and model-tracked outputs.
    bit prev_done = 1'b0;
    always @(negedge CLK) begin
        if (!in_rst) begin
            bit bad;
            bad = 1'b0;
            checks++;
            if (io_done === 1'b1 && io_ready === 1'b1) begin
                bad = 1'b1; $display("FAIL cyc_done_ready: done=%b ready=%b expected not both", io_done, io_ready);
            end
            if (io_done === 1'b1 && prev_done) begin
                bad = 1'b1; $display("FAIL cyc_done_pulse: done high 2 cycles, expected 1-cycle pulse");
            end
            if (!rx_busy && uart_err !== m_err) begin
                bad = 1'b1; $display("FAIL cyc_err: got %b expected %b", uart_err, m_err);
            end
            if (io_done !== 1'b1 && io_rdata !== m_rdata) begin
                bad = 1'b1; $display("FAIL cyc_rdata_hold: got 0x%0h expected 0x%0h", io_rdata, m_rdata);
            end
            if (tx_q.size() == 0 && !mon_busy && uart_txd !== 1'b1) begin
                bad = 1'b1; $display("FAIL cyc_txd_idle: got %b expected 1", uart_txd);
            end
            if (bad) errors++;
            prev_done = (io_done === 1'b1);
        end else begin
            prev_done = 1'b0;
        end
    end

    // TX line decoder: samples each bit mid-period and matches the write order.
    int         mon_gen;
    logic [7:0] mon_b;
    logic       mon_start;
    logic       mon_stop;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge CLK);
            if (uart_txd === 1'b0 && !in_rst) begin
                mon_busy = 1'b1;
                mon_gen  = rst_gen;
                repeat (CPB / 2) @(negedge CLK);
                mon_start = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    mon_b[i] = uart_txd;
                end
                repeat (CPB) @(negedge CLK);
                mon_stop = uart_txd;
                if (mon_gen == rst_gen) begin
                    if (tx_q.size() == 0) begin
                        chk("tx_stale_frame", 32'({mon_start, mon_b, mon_stop}), 32'h0);
                    end else begin
                        mon_exp = tx_q.pop_front();
                        chk("tx_frame", 32'({mon_start, mon_b, mon_stop}), 32'({1'b0, mon_exp, 1'b1}));
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (io_ready !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_before_req", 32'(io_ready), 32'h1);
    endtask

    task automatic do_write(input logic [7:0] b);
        int n;
        wait_ready();
        io_wdata     = b;
        io_write_req = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (io_done !== 1'b1 && n < 600);
        chk("wr_done", 32'(io_done), 32'h1);
        if (io_done === 1'b1) tx_q.push_back(b);
        io_write_req = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] exp, input int hold);
        int n;
        logic dup;
        wait_ready();
        io_read_req = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (io_done !== 1'b1 && n < 600);
        chk("rd_done", 32'(io_done), 32'h1);
        chk("rd_data", 32'(io_rdata), 32'(exp));
        m_rdata = exp;
        if (hold > 0) begin
            dup = 1'b0;
            repeat (hold) begin
                @(negedge CLK);
                if (io_done === 1'b1) dup = 1'b1;
            end
            chk("rd_held_no_second_done", 32'(dup), 32'h0);
        end
        io_read_req = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit to_model);
        rx_busy  = 1'b1;
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge CLK);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge CLK);
        uart_rxd = 1'b1;
        if (to_model) begin
            if (!stop)                   m_err[1] = 1'b1;
            else if (rx_q.size() >= DEPTH) m_err[0] = 1'b1;
            else                         rx_q.push_back(b);
        end
        repeat (4) @(negedge CLK);
        rx_busy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [9:0] fr;
    logic [7:0] got;
    logic [7:0] exp;
    logic       bad1;
    logic       seen;
    int         n3;
    int         op;
    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(io_ready), 32'h1);
        chk("rst_done", 32'(io_done), 32'h0);
        chk("rst_rdata", 32'(io_rdata), 32'h0);
        chk("rst_txd", 32'(uart_txd), 32'h1);
        chk("rst_err", 32'(uart_err), 32'h0);
        RSTN = 1'b1;
        @(negedge CLK);
        in_rst = 1'b0;

        // Write 0xA5: line low two cycles after accept, then LSB-first bits.
        do_write(8'hA5);
        chk("tx_high_in_done_cycle", 32'(uart_txd), 32'h1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            got = {7'd0, fr[k]};
            repeat (CPB) begin
                @(negedge CLK);
                if (uart_txd !== fr[k]) got = {7'd0, uart_txd};
            end
            chk($sformatf("tx_a5_bit%0d", k), 32'(got), 32'(fr[k]));
        end

        send_frame(8'h3C, 1'b1, 1'b1);
        exp = rx_q.pop_front();
        chk("model_pin_3c", 32'(exp), 32'h3C);
        do_read(exp, 5);

        // Read pending on an empty FIFO completes only after a byte arrives.
        wait_ready();
        io_read_req = 1'b1;
        bad1 = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (io_done === 1'b1 || io_ready !== 1'b1) bad1 = 1'b1;
        end
        chk("rd_empty_waits", 32'(bad1), 32'h0);
        seen = 1'b0;
        fork
            send_frame(8'h01, 1'b1, 1'b0);
            begin
                n3 = 0;
                while (io_done !== 1'b1 && n3 < 200) begin
                    @(negedge CLK);
                    n3++;
                end
                seen = (io_done === 1'b1);
                got  = io_rdata;
                m_rdata = 8'h01;
            end
        join
        chk("rd_after_arrival_done", 32'(seen), 32'h1);
        chk("rd_after_arrival_data", 32'(got), 32'h01);
        io_read_req = 1'b0;

        // Randomised mix; RX kept below capacity so the error flags stay clear.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_write(8'($urandom_range(0, 255)));
            end else if (op < 7) begin
                if (rx_q.size() < DEPTH) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
            end else if (rx_q.size() > 0) begin
                do_read(rx_q.pop_front(), $urandom_range(0, 3));
            end
        end
        while (rx_q.size() > 0) do_read(rx_q.pop_front(), 0);
        n3 = 0;
        while ((tx_q.size() > 0 || mon_busy) && n3 < 2000) begin
            @(negedge CLK);
            n3++;
        end
        chk("tx_drained", 32'(tx_q.size()), 32'h0);

        // Overrun: fifth byte dropped, first four delivered in order.
        for (int v = 0; v < 5; v++) send_frame(8'(8'h10 + v), 1'b1, 1'b1);
        chk("overrun_flag", 32'(uart_err), 32'h1);
        for (int i = 0; i < 4; i++) begin
            exp = rx_q.pop_front();
            chk("model_pin_overrun", 32'(exp), 32'(8'h10 + i));
            do_read(exp, 0);
        end

        send_frame(8'h66, 1'b0, 1'b1);
        chk("framing_flag", 32'(uart_err), 32'h3);
        wait_ready();
        io_read_req = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (io_done === 1'b1) seen = 1'b1;
        end
        chk("framing_byte_absent", 32'(seen), 32'h0);
        rx_busy  = 1'b1;
        uart_rxd = 1'b0;
        repeat (2) @(negedge CLK);
        uart_rxd = 1'b1;
        repeat (60) begin
            @(negedge CLK);
            if (io_done === 1'b1) seen = 1'b1;
        end
        rx_busy = 1'b0;
        chk("glitch_no_byte", 32'(seen), 32'h0);
        chk("glitch_no_error", 32'(uart_err), 32'h3);
        io_read_req = 1'b0;

        // Reset mid-frame cuts the line high and discards the queued byte.
        do_write(8'h5A);
        do_write(8'hC3);
        repeat (15) @(negedge CLK);
        in_rst = 1'b1;
        rst_gen++;
        RSTN = 1'b0;
        #1;
        chk("rst_mid_frame_txd", 32'(uart_txd), 32'h1);
        chk("rst_mid_frame_err", 32'(uart_err), 32'h0);
        tx_q.delete();
        rx_q.delete();
        m_err   = 2'b00;
        m_rdata = 8'h00;
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        in_rst = 1'b0;
        chk("post_rst_ready", 32'(io_ready), 32'h1);
        bad1 = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            if (uart_txd !== 1'b1) bad1 = 1'b1;
        end
        chk("post_rst_no_stale_tx", 32'(bad1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_uart_bridge.md
# io_uart_bridge

Byte-wide I/O peripheral that serves the processor's `io_read_req` / `io_write_req` handshake from an 8N1 UART. It sits directly downstream of the processor top. Bytes arriving on the serial line are buffered in an RX FIFO and delivered one per read request; this includes the bootloader's program image. Bytes written by the processor are buffered in a TX FIFO and serialised LSB-first.

## Interface
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit (100 MHz / 115200); legal minimum 4.
- `RX_DEPTH`, 16 — RX FIFO entries; power of two.
- `TX_DEPTH`, 16 — TX FIFO entries; power of two.

- `CLK`  in  1 — single clock; everything is synchronous to its rising edge.
- `RSTN`  in  1 — reset, asynchronous and active-low.
- `io_read_req`  in  1 — level request for one received byte; held until `io_done`.
- `io_write_req`  in  1 — level request to send `io_wdata`; held until `io_done`.
- `io_wdata`  in  8 — write byte; stable while `io_write_req` is high.
- `io_ready`  out  1 — high while the handshake FSM is in IDLE.
- `io_done`  out  1 — one-cycle pulse on completion of a request.
- `io_rdata`  out  8 — read byte; valid in the `io_done` cycle and held until the next read completes.
- `uart_rxd`  in  1 — serial input, asynchronous to `CLK`.
- `uart_txd`  out  1 — serial output, idle high.
- `uart_err`  out  2 — sticky flags: bit0 = RX overrun, bit1 = framing error.

## Operation
- Handshake FSM states:
  - IDLE: `io_ready`=1. A read is accepted when `io_read_req`=1 and the RX FIFO is not empty. A write is accepted when `io_write_req`=1 and the TX FIFO is not full. Otherwise the FSM stays in IDLE; a request may wait indefinitely.
  - DONE: lasts one cycle; `io_done`=1.
  - RELEASE: the FSM waits until both requests are low, then returns to IDLE. This prevents a held request from being serviced twice.
- Read accept: pop the RX FIFO and register the head byte into `io_rdata`.
- Write accept: push `io_wdata` into the TX FIFO.
- Both requests high in IDLE is illegal. The read is serviced and the write is ignored until the next IDLE.
- TX engine:
  - When idle and the TX FIFO is non-empty, pop one byte.
  - Drive a 10-bit frame: start 0, data[0]..data[7], stop 1. Each bit lasts `CLKS_PER_BIT` cycles.
  - Back-to-back frames have no gap beyond the stop bit.
- RX engine:
  - `uart_rxd` passes through a 2-flop synchroniser.
  - A falling edge in idle starts a frame. The start bit is re-checked at `CLKS_PER_BIT/2`; if high, it is a false start and the engine returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT` cycles thereafter.
  - Stop bit sampled 0: discard the byte and set `uart_err[1]`.
  - Valid byte with the RX FIFO full: discard the byte and set `uart_err[0]`.
- Simultaneous RX push and handshake pop on a full RX FIFO: the pop occurs first, so the push succeeds. The same rule applies to the TX FIFO with push and pop swapped.
- Error flags clear only on reset.
- Reset asserted mid-frame or mid-handshake: all state is abandoned immediately. FIFOs are emptied and a partial TX frame is cut off with `uart_txd` forced high.

## Timing
- Reset values:
  - `io_ready`=1, `io_done`=0, `io_rdata`=0x00.
  - `uart_txd`=1, `uart_err`=0.
  - FIFOs empty; FSM in IDLE; TX and RX engines idle.
- Accept in cycle N → `io_done`=1 in cycle N+1 → RELEASE from N+2 → IDLE once both requests are low. Earliest next accept is N+3.
- Write accepted in cycle N with the TX engine idle: pop in N+1, `uart_txd` low from N+2.
- RX byte: pushed into the FIFO one cycle after the mid-stop-bit sample. It is readable by a request in IDLE from the following cycle.
- `io_ready` falls in the cycle after accept and rises in the first IDLE cycle.

## Structure
- Package `io_pkg`:
  - `UART_FRAME_BITS`=10.
  - FSM state enum: IDLE, DONE, RELEASE.
  - Error bit index constants.
- Sub-module `io_sync_fifo` (parameters WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty and pop-before-push on simultaneous access. It is instantiated once for RX and once for TX.
- TX and RX serialisers stay inline in `io_uart_bridge`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and DEPTH=4.
- Write 0xA5 → one `io_done` pulse. `uart_txd` goes low two cycles after accept, then carries 1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
- Drive frame 0x3C on `uart_rxd`, then raise `io_read_req` → `io_done` with `io_rdata`=0x3C. Hold the request 5 extra cycles → no second `io_done`.
- `io_read_req` raised with the RX FIFO empty → `io_ready`=1 and no `io_done` until a frame 0x01 arrives. `io_done` is then asserted with 0x01.
- Five frames 0x10..0x14 with no reads → `uart_err[0]`=1. Four reads return 0x10..0x13.
- Frame with stop bit 0 → `uart_err[1]`=1 and the byte is absent from the RX FIFO. A 2-cycle low glitch on `uart_rxd` → no byte and no error.
- `RSTN` pulsed low mid-TX-frame → `uart_txd`=1 immediately. After release, `io_ready`=1 and no stale TX byte is sent.
